// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the 16-bit CPU.
// Frame = SYNC, count[15:8], count[7:0], count x {word_hi, word_lo}, checksum.
// Words land at BASE_ADDR + 2*index; the CPU is held in reset until a frame
// with a matching 8-bit data checksum has been fully written.
module imem_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          MAX_WORDS = 128,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state_q,     state_d;
   logic [15:0] count_q,     count_d;
   logic [15:0] index_q,     index_d;
   logic [7:0]  sum_q,       sum_d;
   logic [7:0]  word_hi_q,   word_hi_d;
   logic        mem_we_q,    mem_we_d;
   logic [15:0] mem_addr_q,  mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;

   logic        accept;
   logic [15:0] len_full;
   logic [15:0] index_inc;

   // Status outputs decode straight from the state; only WRITE and DONE refuse bytes.
   always_comb begin
      in_ready = !((state_q == S_WRITE) || (state_q == S_DONE));
      cpu_hold = (state_q != S_DONE);
      done     = (state_q == S_DONE);
      error    = (state_q == S_ERROR);
   end

   assign accept    = in_valid && in_ready;
   assign len_full  = {count_q[15:8], in_data};
   assign index_inc = index_q + 16'd1;

   // Next-state logic: each stage consumes one accepted byte, WRITE is a free-running cycle.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      index_d     = index_q;
      sum_d       = sum_q;
      word_hi_d   = word_hi_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         S_IDLE, S_ERROR: begin
            // Only a sync byte opens a frame; everything else is dropped.
            if (accept && (in_data == SYNC_BYTE)) begin
               state_d = S_LEN_HI;
               index_d = 16'd0;
               sum_d   = 8'd0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               count_d[15:8] = in_data;
               state_d       = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               count_d = len_full;
               if (len_full > MAX_COUNT) begin
                  state_d = S_ERROR;
               end else if (len_full == 16'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (accept) begin
               word_hi_d = in_data;
               sum_d     = sum_q + in_data;
               state_d   = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            // Stage the write here so mem_we/addr/wdata are registered during WRITE.
            if (accept) begin
               sum_d       = sum_q + in_data;
               mem_we_d    = 1'b1;
               mem_addr_d  = BASE_ADDR + (index_q << 1);
               mem_wdata_d = {word_hi_q, in_data};
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            index_d = index_inc;
            state_d = (index_inc == count_q) ? S_CHECK : S_DATA_HI;
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q     <= S_IDLE;
         count_q     <= 16'd0;
         index_q     <= 16'd0;
         sum_q       <= 8'd0;
         word_hi_q   <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= BASE_ADDR;
         mem_wdata_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         index_q     <= index_d;
         sum_q       <= sum_d;
         word_hi_q   <= word_hi_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives identical framed streams into two loaders (base 0000
// and base FFFE), predicts written words/outcome from the frame contents and
// checks writes through a queue-based monitor.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;

   logic        rdy0, we0, hold0, done0, err0;
   logic [15:0] addr0, wdata0;
   logic        rdy1, we1, hold1, done1, err1;
   logic [15:0] addr1, wdata1;

   imem_loader #(.BASE_ADDR(16'h0000)) dut0 (
      .CLK(clk), .RESET(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
      .cpu_hold(hold0), .done(done0), .error(err0)
   );

   imem_loader #(.BASE_ADDR(16'hFFFE)) dut1 (
      .CLK(clk), .RESET(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
      .cpu_hold(hold1), .done(done1), .error(err1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] idx;
      logic [15:0] data;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] wq[$];
   int          tests = 0;
   int          fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic finish_now();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   // Write monitor: every mem_we pulse must match the oldest predicted word.
   always @(negedge clk) begin
      if (rst_n && we0) begin
         if (q0.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write0: addr %h data %h, none expected", addr0, wdata0);
         end else begin
            exp_t e;
            logic [15:0] ea;
            e  = q0.pop_front();
            ea = 16'h0000 + 16'(e.idx * 2);
            chk("write_addr0", addr0, ea);
            chk("write_data0", wdata0, e.data);
            chk("ready_low_in_write0", rdy0, 0);
            $display("[TB] dut0 write %h <- %h", addr0, wdata0);
         end
      end
      if (rst_n && we1) begin
         if (q1.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_write1: addr %h data %h, none expected", addr1, wdata1);
         end else begin
            exp_t e;
            logic [15:0] ea;
            e  = q1.pop_front();
            ea = 16'hFFFE + 16'(e.idx * 2);
            chk("write_addr1", addr1, ea);
            chk("write_data1", wdata1, e.data);
            chk("ready_low_in_write1", rdy1, 0);
            $display("[TB] dut1 write %h <- %h", addr1, wdata1);
         end
      end
   end

   task automatic check_reset_outputs();
      chk("rst_mem_we", {we1, we0}, 2'b00);
      chk("rst_addr0", addr0, 16'h0000);
      chk("rst_addr1", addr1, 16'hFFFE);
      chk("rst_wdata", {wdata1, wdata0}, 32'h0);
      chk("rst_hold", {hold1, hold0}, 2'b11);
      chk("rst_done_err", {done1, done0, err1, err0}, 4'b0000);
      chk("rst_ready", {rdy1, rdy0}, 2'b11);
      $display("[TB] reset outputs checked");
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      q0.delete();
      q1.delete();
   endtask

   // Present one byte with random idle gaps; returns once it has been accepted.
   task automatic send_byte(input logic [7:0] b);
      bit acc;
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      acc = 1'b0;
      for (int n = 0; n < 200 && !acc; n++) begin
         acc = rdy0;
         @(posedge clk);
         if (!acc) @(negedge clk);
      end
      if (!acc) begin
         tests++; fails++;
         $display("FAIL handshake_timeout: byte %h never accepted", b);
         finish_now();
      end
   endtask

   task automatic release_bus();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Sends garbage prefix then a frame of 'count' words taken from wq; chk_delta
   // corrupts the checksum. Expected outcome comes from the frame rules alone.
   task automatic send_frame(input int ngarb, input int count, input int chk_delta);
      logic [7:0]  sum;
      logic [15:0] w;
      logic [7:0]  g;
      bit          exp_done;
      sum = 8'h00;
      for (int i = 0; i < ngarb; i++) begin
         g = (i == 0) ? 8'h3C : (i == 1) ? 8'hFF : 8'($urandom);
         if (g == 8'hA5) g = 8'h3C;
         send_byte(g);
      end
      send_byte(8'hA5);
      send_byte(8'(count >> 8));
      send_byte(8'(count));
      if (count <= 128) begin
         for (int i = 0; i < count; i++) begin
            exp_t e;
            w      = wq[i];
            e.idx  = 16'(i);
            e.data = w;
            q0.push_back(e);
            q1.push_back(e);
            sum = sum + w[15:8] + w[7:0];
         end
         for (int i = 0; i < count; i++) begin
            w = wq[i];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
         end
         send_byte(sum + 8'(chk_delta));
         exp_done = (chk_delta == 0);
      end else begin
         exp_done = 1'b0;
      end
      release_bus();
      @(negedge clk);
      chk("frame_done", {done1, done0}, {exp_done, exp_done});
      chk("frame_error", {err1, err0}, {!exp_done, !exp_done});
      chk("frame_hold", {hold1, hold0}, {!exp_done, !exp_done});
      chk("frame_ready", {rdy1, rdy0}, {!exp_done, !exp_done});
      chk("frame_writes_drained", q0.size() + q1.size(), 0);
      $display("[TB] frame count=%0d delta=%0d -> done=%0b error=%0b", count, chk_delta, done0, err0);
   endtask

   task automatic fill_random(input int n);
      wq.delete();
      for (int i = 0; i < n; i++) begin
         logic [15:0] w;
         w = 16'($urandom);
         if ($urandom_range(0, 4) == 0) w[15:8] = 8'hA5;
         wq.push_back(w);
      end
   endtask

   initial begin
      #500000;
      tests++; fails++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_now();
   end

   initial begin
      int n;
      // Reset state
      do_reset();

      // Basic load
      wq = '{16'h1234, 16'hABCD};
      send_frame(0, 2, 0);

      // Bad checksum, then a good frame restarting from ERROR
      do_reset();
      send_frame(0, 2, 1);
      wq = '{16'h0007};
      send_frame(0, 1, 0);

      // Empty frame
      do_reset();
      wq.delete();
      send_frame(0, 0, 0);

      // Oversized length, then garbage-prefixed frame out of ERROR
      do_reset();
      send_frame(0, 129, 0);
      fill_random(3);
      send_frame(2, 3, 0);

      // Randomized frames
      for (int it = 0; it < 6; it++) begin
         do_reset();
         n = $urandom_range(1, 10);
         fill_random(n);
         send_frame($urandom_range(0, 3), n, ($urandom_range(0, 2) == 0) ? 1 : 0);
      end

      // Reset after the first word is written, then a fresh frame
      do_reset();
      fill_random(3);
      begin
         exp_t e;
         e.idx = 16'd0; e.data = wq[0];
         q0.push_back(e); q1.push_back(e);
      end
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(wq[0][15:8]);
      send_byte(wq[0][7:0]);
      release_bus();
      for (int k = 0; k < 20 && (q0.size() != 0); k++) @(negedge clk);
      chk("midframe_first_written", q0.size(), 0);
      do_reset();
      fill_random(2);
      send_frame(0, 2, 0);

      finish_now();
   end

endmodule
